alu4_bist: RTL

ALU4_BIST -- requirements
Module: alu4_bist

---
 rtl/alu4_bist.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu4_bist.sv
// -----------------------------------------------------------------------------
// alu4_bist -- built-in self-test sequencer for a 4-bit ALU slice.
//
// The sequencer drives a fixed table of operand/function vectors onto an
// external ALU. It holds each vector while the ALU settles, compares the
// returned result (and carry-out, for the arithmetic groups) with the
// expected value, and reports a pass/fail summary when the table is done.
//
// Parameters
//   SETTLE      number of WAIT cycles between DRIVE and CHECK (legal 1..7)
//
// Build option
//   ALU4_BIST_SLT_EN  when defined, four set-less-than vectors (16..19) are
//                     appended after the SUB group. By default only vectors
//                     0..15 exist, and function select 11 is never driven.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   run request, honoured only in IDLE or DONE
//   a, b, less  out  [3:0] operand and less drive to the ALU
//   cin, binv   out  carry-in and B-invert drive
//   sel1, sel0  out  function select drive (00 AND, 01 OR, 10 ADD, 11 SLT)
//   result      in   [3:0] ALU result
//   co          in   ALU carry-out
//   busy        out  high in DRIVE, WAIT and CHECK
//   done        out  high in DONE
//   pass        out  done with no mismatches
//   err_count   out  [4:0] mismatching vectors, saturating at 31
//   first_fail  out  [4:0] index of the first mismatch, 5'h1F if none
// -----------------------------------------------------------------------------
module alu4_bist #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] less,
  output logic       cin,
  output logic       binv,
  output logic       sel1,
  output logic       sel0,
  input  logic [3:0] result,
  input  logic       co,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [4:0] first_fail
);

`ifdef ALU4_BIST_SLT_EN
  localparam logic [4:0] LAST_IDX = 5'd19;
`else
  localparam logic [4:0] LAST_IDX = 5'd15;
`endif

  localparam logic [4:0] NO_FAIL   = 5'h1F;
  localparam logic [4:0] ERR_MAX   = 5'd31;
  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // One table entry: what to drive and what to expect back.
  typedef struct packed {
    logic [1:0] sel;
    logic       binv;
    logic       cin;
    logic [3:0] b;
    logic [3:0] less;
    logic [3:0] exp_res;
    logic       exp_co;
    logic       chk_co;
  } vec_t;

  // Registered ALU drive. 'a' is registered too so that reset forces it low.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] less;
    logic       cin;
    logic       binv;
    logic [1:0] sel;
  } drive_t;

  // Vector table. Within each group of four, idx[1:0] picks the B operand;
  // the per-position constants below are packed with position 0 in the
  // least significant nibble/bit.
  function automatic vec_t lookup(input logic [4:0] idx);
    vec_t        v;
    logic [15:0] b_tbl;
    logic [15:0] res_tbl;
    logic [3:0]  co_tbl;
    logic [3:0]  bit_sel;
    v       = '0;
    b_tbl   = 16'hF410;
    res_tbl = 16'h0000;
    co_tbl  = 4'b0000;
    bit_sel = {idx[1:0], 2'b00};
    v.b     = b_tbl[bit_sel +: 4];
    case (idx[4:2])
      3'd0: begin
        v.sel   = 2'b00;
        res_tbl = 16'h5410;
      end
      3'd1: begin
        v.sel   = 2'b01;
        res_tbl = 16'hF555;
      end
      3'd2: begin
        v.sel    = 2'b10;
        res_tbl  = 16'h4965;
        co_tbl   = 4'b1000;
        v.chk_co = 1'b1;
      end
      3'd3: begin
        v.sel    = 2'b10;
        v.binv   = 1'b1;
        v.cin    = 1'b1;
        res_tbl  = 16'h6145;
        co_tbl   = 4'b0111;
        v.chk_co = 1'b1;
      end
`ifdef ALU4_BIST_SLT_EN
      3'd4: begin
        // SLT: the ALU passes 'less' through to result, so the expected
        // result is exactly the less value driven for that vector.
        v.sel   = 2'b11;
        v.binv  = 1'b1;
        v.cin   = 1'b1;
        v.less  = {3'b000, ~idx[0]};
        res_tbl = {12'h000, v.less};
        bit_sel = 4'd0;
      end
`endif
      default: begin
        v = '0;
      end
    endcase
    v.exp_res = res_tbl[bit_sel +: 4];
    v.exp_co  = co_tbl[idx[1:0]];
    return v;
  endfunction

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic [4:0] ff_q, ff_d;
  drive_t     drive_q, drive_d;

  vec_t       cur_vec;
  vec_t       nxt_vec;
  logic       mismatch;
  logic       launch;

  assign cur_vec  = lookup(idx_q);
  assign nxt_vec  = lookup(idx_d);
  assign mismatch = (result != cur_vec.exp_res) ||
                    (cur_vec.chk_co && (co != cur_vec.exp_co));
  assign launch   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE,
      S_DONE:  if (start) state_d = S_DRIVE;
      S_DRIVE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
      S_CHECK: state_d = (idx_q == LAST_IDX) ? S_DONE : S_DRIVE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_DRIVE,
      S_WAIT,
      S_CHECK: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    pass = done && (err_q == 5'd0);
  end

  // ---------------------------------------------------------------------------
  // Datapath: index, settle counter, error bookkeeping, ALU drive
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = 3'd0;
    err_d   = err_q;
    ff_d    = ff_q;
    drive_d = drive_q;

    if (launch) begin
      idx_d = 5'd0;
      err_d = 5'd0;
      ff_d  = NO_FAIL;
    end

    if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 3'd1;
    end

    if (state_q == S_CHECK) begin
      if (mismatch) begin
        if (err_q != ERR_MAX) err_d = err_q + 5'd1;
        if (ff_q == NO_FAIL)  ff_d  = idx_q;
      end
      if (idx_q != LAST_IDX) idx_d = idx_q + 5'd1;
    end

    // The drive registers load only on the edge that enters DRIVE, so the
    // ALU inputs stay frozen through WAIT and CHECK.
    if (state_d == S_DRIVE) begin
      drive_d.a    = 4'h5;
      drive_d.b    = nxt_vec.b;
      drive_d.less = nxt_vec.less;
      drive_d.cin  = nxt_vec.cin;
      drive_d.binv = nxt_vec.binv;
      drive_d.sel  = nxt_vec.sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 5'd0;
      cnt_q   <= 3'd0;
      err_q   <= 5'd0;
      ff_q    <= NO_FAIL;
      drive_q <= '0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      drive_q <= drive_d;
    end
  end

  assign a          = drive_q.a;
  assign b          = drive_q.b;
  assign less       = drive_q.less;
  assign cin        = drive_q.cin;
  assign binv       = drive_q.binv;
  assign sel1       = drive_q.sel[1];
  assign sel0       = drive_q.sel[0];
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule
